emergency_arbiter: RTL



---
 rtl/emergency_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/emergency_arbiter.sv
// emergency_arbiter
// Round-robin arbiter for emergency-vehicle request lines feeding the single
// Emergency input of the intersection light controller. Each grant lasts at
// least HOLD_MIN and at most HOLD_MAX cycles. Every release is followed by a
// COOLDOWN gap so that normal traffic cycling resumes between emergencies.
// A requester released by timeout is locked out until its request drops.
// Optional build macro EMERGENCY_PREEMPT_EN: requester 0 may preempt a grant
// held by any other requester, with no cooldown and no low cycle on Emergency.
module emergency_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MIN = 16,
    parameter int HOLD_MAX = 256,
    parameter int COOLDOWN = 32,
    parameter int CW       = 9
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic             Emergency,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             timeout
);

    localparam int            IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IW:0]   N_W     = (IW+1)'(N_REQ);
    localparam logic [IW-1:0] LAST_IX = IW'(N_REQ - 1);
    localparam logic [CW-1:0] HMIN_M1 = CW'(HOLD_MIN - 1);
    localparam logic [CW-1:0] HMAX_M1 = CW'(HOLD_MAX - 1);
    localparam logic [CW-1:0] CD_M1   = CW'(COOLDOWN - 1);
    localparam logic [N_REQ-1:0] ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_COOLDOWN} state_t;

    state_t            state_reg, state_next;
    logic [N_REQ-1:0]  grant_reg, grant_next;
    logic              emergency_reg, emergency_next;
    logic              busy_reg, busy_next;
    logic              timeout_reg, timeout_next;
    logic [IW-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]     gidx_reg, gidx_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [N_REQ-1:0]  lockout_reg, lockout_next;

    logic [N_REQ-1:0]   eligible;
    logic [2*N_REQ-1:0] rot_dbl;
    logic [IW-1:0]      pick_off;
    logic [IW:0]        sum_w, sub_w;
    logic [IW-1:0]      pick_idx;
    logic [N_REQ-1:0]   pick_onehot;
    logic [CW-1:0]      cnt_inc;
    logic               req_granted;
    logic               normal_rel, forced_rel, set_lock, preempt_hit;

    assign eligible    = req & ~lockout_reg;
    assign req_granted = |(req & grant_reg);
    assign cnt_inc     = (cnt_reg == {CW{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
    assign normal_rel  = (cnt_reg >= HMIN_M1) && !req_granted;
    assign forced_rel  = (cnt_reg == HMAX_M1) && !normal_rel;

`ifdef EMERGENCY_PREEMPT_EN
    assign preempt_hit = (gidx_reg != '0) && req[0] && !lockout_reg[0];
`else
    assign preempt_hit = 1'b0;
`endif

    // Round-robin pick: rotate eligible so rr_ptr sits at bit 0, take the lowest set bit
    always_comb begin
        rot_dbl  = {eligible, eligible} >> rr_ptr_reg;
        pick_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_dbl[k]) pick_off = IW'(k);
        end
        sum_w       = {1'b0, rr_ptr_reg} + {1'b0, pick_off};
        sub_w       = sum_w - N_W;
        pick_idx    = (sum_w >= N_W) ? sub_w[IW-1:0] : sum_w[IW-1:0];
        pick_onehot = ONE << pick_idx;
    end

    // Lockout bits clear whenever their request is low; a forced release locks the holder
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lock
            assign lockout_next[gi] = (lockout_reg[gi] & req[gi]) | (set_lock & grant_reg[gi]);
        end
    endgenerate

    // Next-state and registered-output logic for the grant FSM
    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        emergency_next = emergency_reg;
        busy_next      = busy_reg;
        timeout_next   = 1'b0;
        rr_ptr_next    = rr_ptr_reg;
        gidx_next      = gidx_reg;
        cnt_next       = cnt_reg;
        set_lock       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                grant_next     = '0;
                emergency_next = 1'b0;
                busy_next      = 1'b0;
                cnt_next       = '0;
                if (|eligible) begin
                    state_next     = ST_GRANT;
                    grant_next     = pick_onehot;
                    gidx_next      = pick_idx;
                    emergency_next = 1'b1;
                    busy_next      = 1'b1;
                end
            end
            ST_GRANT: begin
                cnt_next = cnt_inc;
                if (preempt_hit) begin
                    grant_next = ONE;
                    gidx_next  = '0;
                    cnt_next   = '0;
                end else if (normal_rel || forced_rel) begin
                    state_next     = ST_COOLDOWN;
                    grant_next     = '0;
                    emergency_next = 1'b0;
                    busy_next      = 1'b1;
                    cnt_next       = '0;
                    rr_ptr_next    = (gidx_reg == LAST_IX) ? '0 : gidx_reg + 1'b1;
                    timeout_next   = forced_rel;
                    set_lock       = forced_rel;
                end
            end
            ST_COOLDOWN: begin
                cnt_next = cnt_inc;
                if (cnt_reg == CD_M1) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                grant_next     = '0;
                emergency_next = 1'b0;
                busy_next      = 1'b0;
                cnt_next       = '0;
            end
        endcase
    end

    // State register; reset overrides everything and drops any grant at once
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            emergency_reg <= 1'b0;
            busy_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
            rr_ptr_reg    <= '0;
            gidx_reg      <= '0;
            cnt_reg       <= '0;
            lockout_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            emergency_reg <= emergency_next;
            busy_reg      <= busy_next;
            timeout_reg   <= timeout_next;
            rr_ptr_reg    <= rr_ptr_next;
            gidx_reg      <= gidx_next;
            cnt_reg       <= cnt_next;
            lockout_reg   <= lockout_next;
        end
    end

    assign Emergency = emergency_reg;
    assign grant     = grant_reg;
    assign busy      = busy_reg;
    assign timeout   = timeout_reg;

endmodule
